// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: shared opcodes, draw ops, status bit positions and draw-packet layout
package gpu_cmd_pkg;
  localparam int COORD_W_DEF = 10;
  localparam int ST_BUSY = 31;
  localparam int ST_OVF = 30;
  localparam int ST_ILL = 29;
  typedef enum logic [3:0] {
    OP_NOP        = 4'h0,
    OP_SET_COLOR  = 4'h1,
    OP_SET_P1     = 4'h2,
    OP_SET_P2     = 4'h3,
    OP_DRAW_LINE  = 4'h4,
    OP_DRAW_RECT  = 4'h5,
    OP_DRAW_FILL  = 4'h6,
    OP_DRAW_CLEAR = 4'h7,
    OP_CLR_STATUS = 4'hF
  } opcode_e;
  typedef enum logic [1:0] {
    DOP_LINE  = 2'b00,
    DOP_RECT  = 2'b01,
    DOP_FILL  = 2'b10,
    DOP_CLEAR = 2'b11
  } draw_op_e;
  typedef struct packed {
    draw_op_e                 op;
    logic [COORD_W_DEF-1:0]   x1;
    logic [COORD_W_DEF-1:0]   y1;
    logic [COORD_W_DEF-1:0]   x2;
    logic [COORD_W_DEF-1:0]   y2;
    logic [23:0]              color;
  } draw_pkt_t;
  // Opcodes 0x4..0x7 are the draw commands.
  function automatic logic is_draw(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction
  // Draw op is opcode-4, i.e. the low two opcode bits for 0x4..0x7.
  function automatic draw_op_e draw_op(input logic [3:0] op);
    return draw_op_e'(op[1:0]);
  endfunction
endpackage

// File: rtl/apb_cmd_decoder_if.sv
// apb_cmd_decoder_if: command write path from the APB slave plus the draw-packet stream
interface apb_cmd_decoder_if #(parameter int COORD_W = 10);
  logic [31:0]        command_bus;
  logic               penable;
  logic               cmd_ready;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [COORD_W-1:0] cmd_x1;
  logic [COORD_W-1:0] cmd_y1;
  logic [COORD_W-1:0] cmd_x2;
  logic [COORD_W-1:0] cmd_y2;
  logic [23:0]        cmd_color;
  logic [31:0]        status_value;
  modport slave (
    input  command_bus, penable, cmd_ready,
    output cmd_valid, cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color, status_value
  );
  modport master (
    output command_bus, penable, cmd_ready,
    input  cmd_valid, cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color, status_value
  );
endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: draw-packet queue; no fall-through, push-when-full accepted only alongside a pop
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic                   pclk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop_req,
  output logic                   valid,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          pop, wr;
  // Pointer/count next-state; head data reads zero while empty.
  always_comb begin
    valid = cnt_q != '0;
    pop   = pop_req & valid;
    wr    = push & ((cnt_q != FULL) | pop);
    drop  = push & ~wr;
    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(wr);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    dout  = valid ? mem_q[rd_q] : '0;
    count = cnt_q;
  end
  // Pointer and occupancy state, cleared asynchronously.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge pclk) begin
    if (wr) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/apb_cmd_decoder.sv
// apb_cmd_decoder: captures APB command words, decodes them into parameter updates and queued draw packets
module apb_cmd_decoder
  import gpu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 10
) (
  input logic               pclk,
  input logic               n_rst,
  apb_cmd_decoder_if.slave  bus
);
  localparam int PKT_W = 2 + 4*COORD_W + 24;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  logic               pen_q, pen_d, dec_q, dec_d, push_q, push_d;
  logic               ovf_q, ovf_d, ill_q, ill_d;
  logic [31:0]        cmd_q, cmd_d;
  logic [23:0]        color_q, color_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d, head;
  logic [CNT_W-1:0]   count;
  logic [3:0]         op;
  logic               cap, clr, drop, head_vld, unused_cmd;
  assign unused_cmd = ^cmd_q[27:24];
  // Capture on the rising edge of penable, decode one cycle later, push one cycle after that.
  always_comb begin
    op      = cmd_q[31:28];
    pen_d   = bus.penable;
    cap     = bus.penable & ~pen_q;
    cmd_d   = cap ? bus.command_bus : cmd_q;
    dec_d   = cap;
    color_d = (dec_q && op == OP_SET_COLOR) ? cmd_q[23:0] : color_q;
    x1_d    = (dec_q && op == OP_SET_P1) ? cmd_q[2*COORD_W-1:COORD_W] : x1_q;
    y1_d    = (dec_q && op == OP_SET_P1) ? cmd_q[COORD_W-1:0] : y1_q;
    x2_d    = (dec_q && op == OP_SET_P2) ? cmd_q[2*COORD_W-1:COORD_W] : x2_q;
    y2_d    = (dec_q && op == OP_SET_P2) ? cmd_q[COORD_W-1:0] : y2_q;
    push_d  = dec_q && is_draw(op);
    pkt_d   = push_d ? {draw_op(op), x1_q, y1_q, x2_q, y2_q, color_q} : pkt_q;
    clr     = dec_q && op == OP_CLR_STATUS;
    ill_d   = (dec_q && op[3] && op != OP_CLR_STATUS) | (ill_q & ~clr);
    ovf_d   = drop | (ovf_q & ~clr);
  end
  // Command pipeline, parameter registers and sticky flags.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      pen_q   <= 1'b0;
      cmd_q   <= '0;
      dec_q   <= 1'b0;
      color_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      push_q  <= 1'b0;
      pkt_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      pen_q   <= pen_d;
      cmd_q   <= cmd_d;
      dec_q   <= dec_d;
      color_q <= color_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      push_q  <= push_d;
      pkt_q   <= pkt_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(PKT_W)) u_fifo (
    .pclk    (pclk),
    .n_rst   (n_rst),
    .push    (push_q),
    .din     (pkt_q),
    .pop_req (bus.cmd_ready),
    .valid   (head_vld),
    .dout    (head),
    .count   (count),
    .drop    (drop)
  );
  assign bus.cmd_valid = head_vld;
  assign {bus.cmd_op, bus.cmd_x1, bus.cmd_y1, bus.cmd_x2, bus.cmd_y2, bus.cmd_color} = head;
  // Status word assembled from queue occupancy and sticky flags.
  always_comb begin
    bus.status_value          = '0;
    bus.status_value[ST_BUSY] = count != '0;
    bus.status_value[ST_OVF]  = ovf_q;
    bus.status_value[ST_ILL]  = ill_q;
    bus.status_value[3:0]     = 4'(count);
  end
endmodule

// File: tb/tb_apb_cmd_decoder.sv
// tb_apb_cmd_decoder: table-driven status checks plus scoreboarded packet stream
module tb_apb_cmd_decoder;
  import gpu_cmd_pkg::*;
  logic pclk = 1'b0;
  logic n_rst = 1'b0;
  always #5 pclk = ~pclk;
  apb_cmd_decoder_if #(.COORD_W(10)) bus();
  apb_cmd_decoder #(.FIFO_DEPTH(4), .COORD_W(10)) dut (.pclk(pclk), .n_rst(n_rst), .bus(bus));
  typedef struct {
    logic [31:0] cmd;
    logic [31:0] status;
  } vec_t;
  vec_t        tbl [12];
  int          checks = 0;
  int          errors = 0;
  draw_pkt_t   sbq [$];
  logic [23:0] m_color;
  logic [9:0]  m_x1, m_y1, m_x2, m_y2;
  logic [65:0] head, prev_head;
  logic        prev_stall = 1'b0;
  int          first, hi;
  assign head = {bus.cmd_op, bus.cmd_x1, bus.cmd_y1, bus.cmd_x2, bus.cmd_y2, bus.cmd_color};

  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic void model_cmd(input logic [31:0] c);
    draw_pkt_t p;
    case (c[31:28])
      4'h1: m_color = c[23:0];
      4'h2: begin m_x1 = c[19:10]; m_y1 = c[9:0]; end
      4'h3: begin m_x2 = c[19:10]; m_y2 = c[9:0]; end
      4'h4, 4'h5, 4'h6, 4'h7: begin
        p.op = draw_op_e'(2'(c[31:28] - 4'd4));
        p.x1 = m_x1; p.y1 = m_y1; p.x2 = m_x2; p.y2 = m_y2; p.color = m_color;
        if (sbq.size() < 4) sbq.push_back(p);
      end
      default: ;
    endcase
  endfunction

  task automatic wr(input logic [31:0] c);
    model_cmd(c);
    @(posedge pclk); #1;
    bus.command_bus = c;
    bus.penable = 1'b1;
    @(posedge pclk);
    @(posedge pclk); #1;
    bus.penable = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge pclk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge pclk); #1;
    bus.cmd_ready = v;
  endtask

  task automatic drain();
    set_ready(1'b1);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge pclk);
    chk("drain scoreboard empty", 96'(sbq.size()), 96'(0));
    set_ready(1'b0);
    settle();
  endtask

  always @(negedge pclk) begin
    if (n_rst && prev_stall) chk("head held while stalled", 96'(head), 96'(prev_head));
    if (n_rst && bus.cmd_valid && bus.cmd_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected packet: got %0h expected none", head);
      end else chk("popped packet", 96'(head), 96'(sbq.pop_front()));
    end
    prev_stall = n_rst & bus.cmd_valid & ~bus.cmd_ready;
    prev_head  = head;
  end

  initial begin
    bus.command_bus = '0;
    bus.penable = 1'b0;
    bus.cmd_ready = 1'b0;
    m_color = '0; m_x1 = '0; m_y1 = '0; m_x2 = '0; m_y2 = '0;
    tbl[0]  = '{32'h60000000, 32'h80000001};
    tbl[1]  = '{32'h60000000, 32'h80000002};
    tbl[2]  = '{32'h60000000, 32'h80000003};
    tbl[3]  = '{32'h60000000, 32'h80000004};
    tbl[4]  = '{32'h60000000, 32'hC0000004};
    tbl[5]  = '{32'hF0000000, 32'h80000004};
    tbl[6]  = '{32'hA0000000, 32'hA0000004};
    tbl[7]  = '{32'h00000000, 32'hA0000004};
    tbl[8]  = '{32'hE0000000, 32'hA0000004};
    tbl[9]  = '{32'hF0000000, 32'h80000004};
    tbl[10] = '{32'h80000000, 32'hA0000004};
    tbl[11] = '{32'hF0000000, 32'h80000004};
    repeat (2) @(negedge pclk);
    chk("reset cmd_valid", 96'(bus.cmd_valid), 96'(0));
    chk("reset status", 96'(bus.status_value), 96'(0));
    chk("reset head data", 96'(head), 96'(0));
    @(posedge pclk); #1;
    n_rst = 1'b1;
    // single packet with exact valid timing
    set_ready(1'b1);
    wr(32'h11FF0000);
    wr(32'h20001407);
    wr(32'h30019032);
    settle();
    model_cmd(32'h50000000);
    @(posedge pclk); #1;
    bus.command_bus = 32'h50000000;
    bus.penable = 1'b1;
    first = -1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (i == 2) bus.penable = 1'b0;
      if (bus.cmd_valid) begin
        hi++;
        if (first < 0) first = i;
      end
      if (i == 3) chk("single packet fields", 96'(head), 96'({2'b01, 10'd5, 10'd7, 10'd100, 10'd50, 24'hFF0000}));
    end
    chk("single packet valid cycles", 96'(hi), 96'(1));
    chk("single packet latency", 96'(first), 96'(3));
    // two-cycle penable pulse pushes exactly once
    set_ready(1'b0);
    wr(32'h40000000);
    settle();
    chk("pulse width count", 96'(bus.status_value), 96'(32'h80000001));
    drain();
    // illegal opcode sets flag without pushing
    wr(32'hA0000000);
    settle();
    chk("illegal flag", 96'(bus.status_value), 96'(32'h20000000));
    wr(32'hF0000000);
    settle();
    chk("illegal cleared", 96'(bus.status_value), 96'(0));
    // overflow / clear / illegal table with the sink stalled
    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].cmd);
      settle();
      chk($sformatf("vec%0d status", i), 96'(bus.status_value), 96'(tbl[i].status));
    end
    drain();
    chk("status after drain", 96'(bus.status_value), 96'(0));
    // parameters snapshotted at push time
    wr(32'h10123456);
    wr(32'h40000000);
    settle();
    chk("snapshot head color", 96'(bus.cmd_color), 96'(24'h123456));
    wr(32'h1000FF00);
    settle();
    chk("snapshot after SET_COLOR", 96'(bus.cmd_color), 96'(24'h123456));
    drain();
    // reset with queued packets and a captured-but-undecoded command
    wr(32'h70000000);
    wr(32'h70000000);
    wr(32'h70000000);
    settle();
    chk("three queued", 96'(bus.status_value), 96'(32'h80000003));
    @(posedge pclk); #1;
    bus.command_bus = 32'h11ABCDEF;
    bus.penable = 1'b1;
    @(posedge pclk); #3;
    n_rst = 1'b0;
    bus.penable = 1'b0;
    sbq.delete();
    m_color = '0; m_x1 = '0; m_y1 = '0; m_x2 = '0; m_y2 = '0;
    #1;
    chk("reset cmd_valid immediate", 96'(bus.cmd_valid), 96'(0));
    chk("reset status immediate", 96'(bus.status_value), 96'(0));
    @(posedge pclk); #1;
    n_rst = 1'b1;
    settle();
    chk("post-reset status", 96'(bus.status_value), 96'(0));
    wr(32'h50000000);
    settle();
    chk("post-reset status one", 96'(bus.status_value), 96'(32'h80000001));
    chk("post-reset color", 96'(bus.cmd_color), 96'(0));
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
